// File: rtl/digit_serial_adder.sv
// Digit-serial two's-complement add/sub: DIGIT bits per cycle, LSB digit first; result valid NDIG cycles after accept.
// Backpressure: the result is held in DONE until out_ready, and no new operands are accepted until it is taken.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NDIG = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (DIGIT < 1) begin : g_bad_digit
            $error("digit_serial_adder: DIGIT must be at least 1");
        end else if (WIDTH % DIGIT != 0) begin : g_bad_width
            $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic             ovf_r;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_sum;
    logic             d_cout;
    logic             msb_cin;

    assign a_dig = a_sh[DIGIT-1:0];
    assign b_dig = b_sh[DIGIT-1:0];
    assign {d_cout, d_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    // Carry into the digit's top bit, recovered from its sum bit; only used on the last digit.
    assign msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ d_sum[DIGIT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= sub ? ~b : b;
                        carry <= sub | cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // New digits enter at the top; after NDIG shifts the word is complete and aligned.
                    sum_r <= (sum_r >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= d_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_r <= d_cout;
                        ovf_r  <= msb_cin ^ d_cout;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: DIGIT=4, 1 and 16 instances checked against a signed/unsigned arithmetic model.
module tb_digit_serial_adder;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [W-1:0] a         [3];
    logic [W-1:0] b         [3];
    logic         cin       [3];
    logic         sub       [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [W-1:0] sum       [3];
    logic         cout      [3];
    logic         ovf       [3];

    int vectors = 0;
    int errors  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DG = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        digit_serial_adder #(.WIDTH(W), .DIGIT(DG)) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .a(a[g]), .b(b[g]), .cin(cin[g]), .sub(sub[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .sum(sum[g]), .cout(cout[g]), .ovf(ovf[g])
        );
    end

    function automatic int ndig(input int u);
        return (u == 0) ? 4 : ((u == 1) ? 16 : 1);
    endfunction

    // Returns {ovf, cout, sum} from integer arithmetic on the operand values.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic s);
        int sx, sy, r;
        logic co, ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = sx - sy;
            co = (x >= y);
        end else begin
            r  = sx + sy + int'(c);
            co = (int'(x) + int'(y) + int'(c)) > ((1 << W) - 1);
        end
        ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
        return {ov, co, r[W-1:0]};
    endfunction

    task automatic run_op(input int u, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, input logic s, input string nm);
        logic [W+1:0] e;
        int t0;
        bit seen;
        e = model(x, y, c, s);
        a[u] = x; b[u] = y; cin[u] = c; sub[u] = s;
        in_valid[u] = 1'b1; out_ready[u] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[u]) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen) begin
            errors++; $display("FAIL %s accept: in_ready=0 expected 1", nm);
            in_valid[u] = 1'b0;
            return;
        end
        t0 = cyc;
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        a[u] = W'($urandom); b[u] = W'($urandom);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid[u]) begin seen = 1'b1; break; end
        end
        vectors++;
        if (!seen) begin
            errors++; $display("FAIL %s timeout: out_valid never rose", nm);
            return;
        end
        vectors++;
        if (cyc - t0 - 1 != ndig(u)) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", nm, cyc - t0 - 1, ndig(u));
        end
        vectors++;
        if ({ovf[u], cout[u], sum[u]} !== e) begin
            errors++;
            $display("FAIL %s result: ovf/cout/sum got %b/%b/%h expected %b/%b/%h",
                     nm, ovf[u], cout[u], sum[u], e[W+1], e[W], e[W-1:0]);
        end
        vectors++;
        if (in_ready[u] !== 1'b0) begin
            errors++; $display("FAIL %s in_ready_in_done: got %b expected 0", nm, in_ready[u]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            vectors++;
            if ({in_ready[u], out_valid[u], ovf[u], cout[u], sum[u]} !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: in_ready/out_valid/ovf/cout/sum got %b/%b/%b/%b/%h expected all 0",
                         u, in_ready[u], out_valid[u], ovf[u], cout[u], sum[u]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            vectors++;
            if (in_ready[u] !== 1'b1) begin
                errors++; $display("FAIL reset_release[%0d]: in_ready got %b expected 1", u, in_ready[u]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, "add_basic");
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "add_wrap");
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, "add_ovf");
        run_op(0, 16'h0000, 16'h0000, 1'b1, 1'b0, "add_cin");
    endtask

    task automatic test_sub();
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_op(int'($urandom_range(2, 0)), W'($urandom), W'($urandom),
                   1'($urandom), 1'($urandom), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] e;
        bit seen;
        e = model(16'h1357, 16'h2468, 1'b1, 1'b0);
        a[0] = 16'h1357; b[0] = 16'h2468; cin[0] = 1'b1; sub[0] = 1'b0;
        out_ready[0] = 1'b0; in_valid[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[0]) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b1; a[0] = 16'hFFFF;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        for (int i = 0; i < 40 && seen; i++) begin
            @(negedge clk);
            if (out_valid[0]) break;
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({out_valid[0], in_ready[0], ovf[0], cout[0], sum[0]} !== {2'b10, e}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: out_valid/in_ready/ovf/cout/sum got %b/%b/%b/%b/%h expected 1/0/%b/%b/%h",
                         i, out_valid[0], in_ready[0], ovf[0], cout[0], sum[0], e[W+1], e[W], e[W-1:0]);
            end
            if (i < 5) @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid[0], in_ready[0], ovf[0], cout[0], sum[0]} !== {2'b01, e}) begin
            errors++;
            $display("FAIL backpressure_release: out_valid/in_ready/ovf/cout/sum got %b/%b/%b/%b/%h expected 0/1/%b/%b/%h",
                     out_valid[0], in_ready[0], ovf[0], cout[0], sum[0], e[W+1], e[W], e[W-1:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit spurious;
        a[0] = 16'hFFFF; b[0] = 16'h0001; cin[0] = 1'b1; sub[0] = 1'b0;
        out_ready[0] = 1'b1; in_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready[0]) break;
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready[0] !== 1'b0) begin
            errors++; $display("FAIL reset_mid_in_ready: got %b expected 0", in_ready[0]);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid[0], in_ready[0], ovf[0], cout[0], sum[0]} !== {2'b01, {(W+2){1'b0}}}) begin
            errors++;
            $display("FAIL reset_mid_state: out_valid/in_ready/ovf/cout/sum got %b/%b/%b/%b/%h expected 0/1/0/0/0000",
                     out_valid[0], in_ready[0], ovf[0], cout[0], sum[0]);
        end
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0]) spurious = 1'b1;
        end
        vectors++;
        if (spurious) begin
            errors++; $display("FAIL reset_mid_abort: out_valid got 1 expected 0");
        end
        @(posedge clk); #1;
        run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, "reset_mid_next");
    endtask

    task automatic test_back_to_back(input int u);
        logic [W+1:0] exp_q[$];
        int acc_t[$];
        int n_acc, n_done;
        logic [W+1:0] e;
        n_acc = 0; n_done = 0;
        out_ready[u] = 1'b1;
        a[u] = W'($urandom); b[u] = W'($urandom); cin[u] = 1'($urandom); sub[u] = 1'($urandom);
        in_valid[u] = 1'b1;
        for (int t = 0; t < 200 && n_done < 3; t++) begin
            @(negedge clk);
            vectors++;
            if (in_ready[u] && out_valid[u]) begin
                errors++; $display("FAIL b2b[%0d] overlap: in_ready and out_valid both 1, expected exclusive", u);
            end
            if (out_valid[u]) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b[%0d] spurious: out_valid=1 expected 0", u);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf[u], cout[u], sum[u]} !== e) begin
                        errors++;
                        $display("FAIL b2b[%0d] result: ovf/cout/sum got %b/%b/%h expected %b/%b/%h",
                                 u, ovf[u], cout[u], sum[u], e[W+1], e[W], e[W-1:0]);
                    end
                end
                n_done++;
            end
            if (in_ready[u] && n_acc < 3) begin
                exp_q.push_back(model(a[u], b[u], cin[u], sub[u]));
                acc_t.push_back(cyc);
                n_acc++;
                @(posedge clk); #1;
                if (n_acc == 3) begin
                    in_valid[u] = 1'b0;
                end else begin
                    a[u] = W'($urandom); b[u] = W'($urandom);
                    cin[u] = 1'($urandom); sub[u] = 1'($urandom);
                end
            end
        end
        in_valid[u] = 1'b0;
        vectors++;
        if (n_done != 3) begin
            errors++; $display("FAIL b2b[%0d] count: got %0d results expected 3", u, n_done);
        end
        for (int i = 1; i < acc_t.size(); i++) begin
            vectors++;
            if (acc_t[i] - acc_t[i-1] != ndig(u) + 2) begin
                errors++;
                $display("FAIL b2b[%0d] spacing: got %0d cycles expected %0d", u, acc_t[i] - acc_t[i-1], ndig(u) + 2);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u] = 1'b0; a[u] = '0; b[u] = '0; cin[u] = 1'b0; sub[u] = 1'b0; out_ready[u] = 1'b1;
        end
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
